// File: rtl/alu_seq_if.sv
// Operand/result bundle between the stack control unit and alu_seq.
//
// Handshake: the master raises start for one or more cycles with oper/a/b
// valid; the ALU samples start only while busy=0 and latches oper/a/b on that
// edge. busy=1 marks a multi-cycle op in flight (start is ignored, not queued).
// done pulses high for exactly one cycle when result/overflow/div_by_zero are
// updated; those outputs then hold until the next done. A start raised during
// the done cycle is accepted on the following edge.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       oper;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             div_by_zero;
  logic             dbg_iter;   // FSM state visibility: 1 while in ITER

  modport master (
    output start, oper, a, b,
    input  busy, done, result, overflow, div_by_zero, dbg_iter
  );

  modport slave (
    input  start, oper, a, b,
    output busy, done, result, overflow, div_by_zero, dbg_iter
  );
endinterface

// File: rtl/alu_seq.sv
// Registered stack-processor ALU: legacy single-cycle ops 0-9, shifts,
// and iterative (one bit per cycle) unsigned multiply/divide/remainder.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SELA = 4'd5;
  localparam logic [3:0] OP_SELB = 4'd6;
  localparam logic [3:0] OP_NEQ  = 4'd7;
  localparam logic [3:0] OP_NZ   = 4'd8;
  localparam logic [3:0] OP_BLTA = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_REM  = 4'd12;
  localparam logic [3:0] OP_SHL  = 4'd13;
  localparam logic [3:0] OP_SHR  = 4'd14;

  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {IDLE, ITER} state_t;

  state_t           r_state, w_next_state;
  logic             r_done, r_ovf, r_dbz;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi;    // MUL: partial product high half; DIV: remainder
  logic [WIDTH-1:0] r_lo;    // MUL: multiplier / product low half; DIV: dividend / quotient
  logic [WIDTH-1:0] r_opb;   // MUL: multiplicand; DIV: divisor
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_sum, w_diff;
  logic             w_b_big, w_launch_iter;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf, w_dbz;
  logic [WIDTH:0]   w_mac;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  logic [WIDTH+1:0] w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_div_r, w_div_q;

  // Single-cycle results straight from the live operands (used only on the launch edge)
  always_comb begin
    w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
    w_b_big = (bus.b >= WIDTH_V);
    w_res   = '0;
    w_ovf   = 1'b0;
    w_dbz   = 1'b0;
    case (bus.oper)
      OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_ovf = w_sum[WIDTH];  end
      OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_ovf = w_diff[WIDTH]; end
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_SELA: w_res = bus.a;
      OP_SELB: w_res = bus.b;
      OP_NEQ:  w_res = WIDTH'(bus.a != bus.b);
      OP_NZ:   w_res = WIDTH'(bus.a != '0);
      OP_BLTA: w_res = WIDTH'(bus.b < bus.a);
      // DIV/REM only reach this path when b=0; nonzero divisors iterate
      OP_DIV:  begin w_res = '1;    w_dbz = 1'b1; end
      OP_REM:  begin w_res = bus.a; w_dbz = 1'b1; end
      OP_SHL:  w_res = w_b_big ? '0 : (bus.a << bus.b);
      OP_SHR:  w_res = w_b_big ? '0 : (bus.a >> bus.b);
      default: w_res = '0;
    endcase
    w_launch_iter = bus.start &&
                    ((bus.oper == OP_MUL) ||
                     (((bus.oper == OP_DIV) || (bus.oper == OP_REM)) && (bus.b != '0)));
  end

  // One shift-add multiply step and one restoring-divide step
  always_comb begin
    w_mac    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_mul_hi = w_mac[WIDTH:1];
    w_mul_lo = {w_mac[0], r_lo[WIDTH-1:1]};
    w_trial  = {1'b0, r_hi, r_lo[WIDTH-1]} - {2'b00, r_opb};
    w_fits   = ~w_trial[WIDTH+1];
    w_div_r  = w_fits ? w_trial[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    w_div_q  = {r_lo[WIDTH-2:0], w_fits};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state: enter ITER on a multi-cycle launch, leave after the last bit
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_launch_iter) w_next_state = ITER;
      ITER:    if (r_cnt == '0)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration registers, result/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_launch_iter) begin
            r_op  <= bus.oper;
            r_hi  <= '0;
            r_cnt <= CNT_LAST;
            if (bus.oper == OP_MUL) begin
              r_lo  <= bus.b;
              r_opb <= bus.a;
            end else begin
              r_lo  <= bus.a;
              r_opb <= bus.b;
            end
          end else if (bus.start) begin
            r_result <= w_res;
            r_ovf    <= w_ovf;
            r_dbz    <= w_dbz;
            r_done   <= 1'b1;
          end
        end
        ITER: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_op == OP_MUL) begin
            r_hi <= w_mul_hi;
            r_lo <= w_mul_lo;
          end else begin
            r_hi <= w_div_r;
            r_lo <= w_div_q;
          end
          if (r_cnt == '0) begin
            r_done <= 1'b1;
            r_dbz  <= 1'b0;
            if (r_op == OP_MUL) begin
              r_result <= w_mul_lo;
              r_ovf    <= |w_mul_hi;
            end else begin
              r_result <= (r_op == OP_DIV) ? w_div_q : w_div_r;
              r_ovf    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state == ITER);
  assign bus.dbg_iter    = (r_state == ITER);
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.overflow    = r_ovf;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomized bench for alu_seq with an expected-result queue.
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;

  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W+1:0] exp_q[$];     // {div_by_zero, overflow, result}
  int           edge_q[$];    // edge index at which done is expected

  // Reference model written from the opcode table
  function automatic logic [W+1:0] model(input logic [3:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [W:0]     s;
    logic [W-1:0]   r;
    logic           o, z;
    r = '0; o = 1'b0; z = 1'b0; p = '0; s = '0;
    case (op)
      4'd0:  begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; o = s[W]; end
      4'd1:  begin r = a - b; o = (a < b); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a;
      4'd6:  r = b;
      4'd7:  r = (a != b) ? 16'd1 : 16'd0;
      4'd8:  r = (a != 0) ? 16'd1 : 16'd0;
      4'd9:  r = (b < a) ? 16'd1 : 16'd0;
      4'd10: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; o = (p[2*W-1:W] != 0); end
      4'd11: if (b == 0) begin r = '1; z = 1'b1; end else r = a / b;
      4'd12: if (b == 0) begin r = a;  z = 1'b1; end else r = a % b;
      4'd13: r = (b >= W) ? '0 : (a << b);
      4'd14: r = (b >= W) ? '0 : (a >> b);
      default: r = '0;
    endcase
    return {z, o, r};
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a start for one edge, then scramble the operands
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.oper  = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    bus.oper  = 4'($urandom_range(0, 15));
    bus.a     = W'($urandom_range(0, 16'hFFFF));
    bus.b     = W'($urandom_range(0, 16'hFFFF));
  endtask

  // Drive an op the DUT is expected to accept and record its outcome
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit multi;
    multi = (op == 4'd10) || (((op == 4'd11) || (op == 4'd12)) && (b != 0));
    exp_q.push_back(model(op, a, b));
    edge_q.push_back(cyc + 1 + (multi ? W : 0));
    drive(op, a, b);
  endtask

  // Wait (bounded) for done, then compare against the queue head
  task automatic expect_done(input string tag);
    logic [W+1:0] e;
    int           ed;
    int           n;
    n = 0;
    while (bus.done !== 1'b1 && n < W + 4) begin
      step();
      n++;
    end
    check({tag, " done"}, W'(bus.done), W'(1));
    e  = exp_q.pop_front();
    ed = edge_q.pop_front();
    check({tag, " edge"}, W'(cyc), W'(ed));
    check({tag, " result"}, bus.result, e[W-1:0]);
    check({tag, " overflow"}, W'(bus.overflow), W'(e[W]));
    check({tag, " div_by_zero"}, W'(bus.div_by_zero), W'(e[W+1]));
    check({tag, " busy"}, W'(bus.busy), W'(0));
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb, held;
    bit           saw_done;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.oper  = '0;
    bus.a     = '0;
    bus.b     = '0;
    step();
    step();
    check("rst busy", W'(bus.busy), W'(0));
    check("rst done", W'(bus.done), W'(0));
    check("rst result", bus.result, W'(0));
    check("rst overflow", W'(bus.overflow), W'(0));
    check("rst dbz", W'(bus.div_by_zero), W'(0));
    reset = 1'b0;
    step();

    // ADD carry, then no carry; done must drop after one cycle and result hold
    issue(4'd0, 16'hFFFF, 16'h0001); expect_done("add_carry");
    issue(4'd0, 16'hFFFE, 16'h0001); expect_done("add_nocarry");
    step();
    check("add pulse end", W'(bus.done), W'(0));
    check("add hold", bus.result, 16'hFFFF);

    // Legacy compares and SUB borrow
    issue(4'd7, 16'h0ABC, 16'h0ABC); expect_done("neq_eq");
    issue(4'd8, 16'h0000, 16'h1234); expect_done("nz_zero");
    issue(4'd8, 16'hCA11, 16'h0000); expect_done("nz_nonzero");
    issue(4'd9, 16'hDEAF, 16'hDEAD); expect_done("blta");
    issue(4'd1, 16'h0000, 16'h0001); expect_done("sub_borrow");
    issue(4'd4, 16'hF0F0, 16'h0FF0); expect_done("xor");

    // Iterative multiply
    issue(4'd10, 16'h0123, 16'h0010);
    check("mul busy", W'(bus.busy), W'(1));
    check("mul dbg_iter", W'(bus.dbg_iter), W'(1));
    expect_done("mul");
    issue(4'd10, 16'h1000, 16'h0010); expect_done("mul_ovf");

    // Divide / remainder, including divide by zero
    issue(4'd11, 16'hDEAD, 16'h0010); expect_done("div");
    issue(4'd12, 16'hDEAD, 16'h0010); expect_done("rem");
    issue(4'd11, 16'h1234, 16'h0000); expect_done("div_zero");
    issue(4'd12, 16'h1234, 16'h0000); expect_done("rem_zero");
    issue(4'd0,  16'h0001, 16'h0002); expect_done("dbz_clear");

    // Shifts at and beyond the width boundary, reserved opcode
    issue(4'd13, 16'h00F1, 16'd4);  expect_done("shl4");
    issue(4'd13, 16'h0001, 16'd15); expect_done("shl15");
    issue(4'd14, 16'h8000, 16'd15); expect_done("shr15");
    issue(4'd14, 16'hFFFF, 16'd16); expect_done("shr16");
    issue(4'd15, 16'hFFFF, 16'hFFFF); expect_done("reserved");

    // Start while busy is ignored; start on the done cycle is accepted
    issue(4'd10, 16'h00FF, 16'h0101);
    step(); step(); step(); step();
    drive(4'd0, 16'h0001, 16'h0001);
    check("ignored busy", W'(bus.busy), W'(1));
    expect_done("mul_ignore");
    issue(4'd0, 16'h1111, 16'h2222);
    expect_done("add_on_done");
    step();
    check("no extra done", W'(bus.done), W'(0));

    // Reset mid-divide: no done, outputs cleared, next op completes
    held = bus.result;
    drive(4'd11, 16'hDEAD, 16'h0003);
    step(); step(); step(); step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst busy", W'(bus.busy), W'(0));
    check("midrst done", W'(bus.done), W'(0));
    check("midrst result", bus.result, W'(0));
    check("midrst held nonzero", W'(held != 0), W'(1));
    saw_done = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      step();
    end
    check("midrst no done", W'(saw_done), W'(0));
    issue(4'd0, 16'h0005, 16'h0007); expect_done("after_rst");

    // Randomized ops over the full opcode range
    for (int i = 0; i < 10; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = W'($urandom_range(0, 16'hFFFF));
      if (rop >= 4'd13)
        rb = W'($urandom_range(0, 20));
      else if ($urandom_range(0, 3) == 0)
        rb = '0;
      else
        rb = W'($urandom_range(0, 16'hFFFF));
      issue(rop, ra, rb);
      expect_done($sformatf("rand%0d_op%0d", i, rop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
